// File: rtl/simple_proc_pkg.sv
// simple_proc_pkg
// Shared definitions for the CPU/host RAM arbiter: bus widths, the default
// burst limit for host locks, the arbiter state encoding and a small helper
// that recognises the final beat of a locked burst.
package simple_proc_pkg;

  localparam int unsigned ADDR_W        = 7;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned BEAT_W        = 4;
  localparam int unsigned BURST_MAX_DEF = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_LOCK = 2'd2
  } arb_state_e;

  // True when the host beat granted now (on top of beats_done already
  // taken) exhausts the burst allowance.
  function automatic logic is_last_beat(input beat_t beats_done, input beat_t limit);
    beat_t next_count;
    next_count = beats_done + 4'd1;
    return (next_count == limit);
  endfunction

endpackage

// File: rtl/simple_proc_ram_arb_if.sv
// simple_proc_ram_arb_if
// Bundles the two requester ports (CPU "c_*", host "h_*"), the shared read
// data / lock status and the strobes towards the external 16x128 data RAM.
//   master : the requesters plus the RAM model (drive requests and ram_dout)
//   slave  : the arbiter (drives grants, rvld, rdata, locked, RAM strobes)
interface simple_proc_ram_arb_if;
  import simple_proc_pkg::*;

  logic  c_req;
  logic  c_we;
  addr_t c_addr;
  data_t c_wdata;
  logic  c_gnt;
  logic  c_rvld;

  logic  h_req;
  logic  h_we;
  logic  h_lock;
  addr_t h_addr;
  data_t h_wdata;
  logic  h_gnt;
  logic  h_rvld;

  data_t rdata;
  logic  locked;

  logic  ram_read_en;
  logic  ram_write_en;
  addr_t ram_addr;
  data_t ram_din;
  data_t ram_dout;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output h_req, h_we, h_lock, h_addr, h_wdata,
    output ram_dout,
    input  c_gnt, c_rvld, h_gnt, h_rvld, rdata, locked,
    input  ram_read_en, ram_write_en, ram_addr, ram_din
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  h_req, h_we, h_lock, h_addr, h_wdata,
    input  ram_dout,
    output c_gnt, c_rvld, h_gnt, h_rvld, rdata, locked,
    output ram_read_en, ram_write_en, ram_addr, ram_din
  );

endinterface

// File: rtl/simple_proc_rr_lock.sv
// simple_proc_rr_lock
// Grant decision for the two requesters: round-robin on ties (last-grant
// register, reset to "host" so the CPU wins the first tie), host-only grants
// while a burst lock is held, and the beat counter that bounds a lock.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_lock       : arbiter is in the LOCK state
//   post_release  : first cycle after a lock was released (CPU preferred)
//   c_req/h_req   : raw requests; h_lock : host asks for a burst lock
//   c_win/h_win   : combinational grants (never both, zero during rst)
//   burst_done    : the host beat granted now is the last one allowed
module simple_proc_rr_lock
  import simple_proc_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_lock,
  input  logic post_release,
  input  logic c_req,
  input  logic h_req,
  input  logic h_lock,
  output logic c_win,
  output logic h_win,
  output logic burst_done
);

  localparam beat_t BURST_LIM = BEAT_W'(BURST_MAX);

  logic  last_host_r;
  beat_t beat_cnt_r;

  // Grant selection: lock gives the host the bus, otherwise round-robin on ties.
  always_comb begin
    c_win = 1'b0;
    h_win = 1'b0;
    if (rst) begin
      c_win = 1'b0;
      h_win = 1'b0;
    end else if (in_lock) begin
      h_win = h_req;
    end else if (c_req && h_req) begin
      // Right after a release the CPU always takes the tie so that two host
      // bursts can never run back to back while the CPU is waiting.
      if (post_release || last_host_r) begin
        c_win = 1'b1;
      end else begin
        h_win = 1'b1;
      end
    end else begin
      c_win = c_req;
      h_win = h_req;
    end
  end

  // Last-beat detection; outside a lock the locking beat itself is beat one.
  always_comb begin
    burst_done = 1'b0;
    if (in_lock) begin
      burst_done = is_last_beat(beat_cnt_r, BURST_LIM);
    end else begin
      burst_done = (BURST_LIM == 4'd1);
    end
  end

  // Last-grant register and lock beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_host_r <= 1'b1;
      beat_cnt_r  <= 4'd0;
    end else begin
      if (c_win) begin
        last_host_r <= 1'b0;
      end else if (h_win) begin
        last_host_r <= 1'b1;
      end else begin
        last_host_r <= last_host_r;
      end

      if (in_lock) begin
        beat_cnt_r <= h_win ? (beat_cnt_r + 4'd1) : beat_cnt_r;
      end else if (h_win && h_lock) begin
        beat_cnt_r <= 4'd1;
      end else begin
        beat_cnt_r <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/simple_proc_ram_arb.sv
// simple_proc_ram_arb
// Arbitrates a CPU port and a host (loader/debug) port onto one external
// single-port RAM with registered read data. One access per cycle; grants are
// combinational so the winner's address/data reach the RAM in the grant
// cycle, and read data returns one cycle later on the shared rdata bus.
// The host may lock the RAM for up to BURST_MAX consecutive beats.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (also forces all outputs to zero)
//   bus : simple_proc_ram_arb_if.slave (requesters, rdata/locked, RAM side)
module simple_proc_ram_arb
  import simple_proc_pkg::*;
#(
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input logic               clk,
  input logic               rst,
  simple_proc_ram_arb_if.slave bus
);

  arb_state_e state_r;
  arb_state_e state_s;

  logic c_win_s;
  logic h_win_s;
  logic burst_done_s;
  logic in_lock_s;
  logic lock_start_s;
  logic lock_end_s;
  logic rvld_any_s;

  logic released_r;
  logic c_rvld_r;
  logic h_rvld_r;

  assign in_lock_s = (state_r == ST_LOCK);

  simple_proc_rr_lock #(
    .BURST_MAX(BURST_MAX)
  ) u_rr_lock (
    .clk          (clk),
    .rst          (rst),
    .in_lock      (in_lock_s),
    .post_release (released_r),
    .c_req        (bus.c_req),
    .h_req        (bus.h_req),
    .h_lock       (bus.h_lock),
    .c_win        (c_win_s),
    .h_win        (h_win_s),
    .burst_done   (burst_done_s)
  );

  // Lock entry/exit conditions; a one-beat allowance never enters LOCK.
  always_comb begin
    lock_start_s = 1'b0;
    lock_end_s   = 1'b0;
    if (in_lock_s) begin
      lock_end_s = !bus.h_lock || !bus.h_req || burst_done_s;
    end else begin
      lock_start_s = h_win_s && bus.h_lock && !burst_done_s;
    end
  end

  // Next-state logic; IDLE arbitrates like ARB so a request is served at once.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (lock_start_s) begin
          state_s = ST_LOCK;
        end else if (bus.c_req || bus.h_req) begin
          state_s = ST_ARB;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (lock_start_s) begin
          state_s = ST_LOCK;
        end else if (!bus.c_req && !bus.h_req) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ARB;
        end
      end
      ST_LOCK: begin
        if (lock_end_s) begin
          state_s = ST_ARB;
        end else begin
          state_s = ST_LOCK;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Grant and RAM-side outputs driven from the current winner.
  always_comb begin
    bus.c_gnt        = c_win_s;
    bus.h_gnt        = h_win_s;
    bus.ram_addr     = 7'd0;
    bus.ram_din      = 16'd0;
    bus.ram_read_en  = 1'b0;
    bus.ram_write_en = 1'b0;
    if (h_win_s) begin
      bus.ram_addr     = bus.h_addr;
      bus.ram_din      = bus.h_wdata;
      bus.ram_read_en  = !bus.h_we;
      bus.ram_write_en = bus.h_we;
    end else if (c_win_s) begin
      bus.ram_addr     = bus.c_addr;
      bus.ram_din      = bus.c_wdata;
      bus.ram_read_en  = !bus.c_we;
      bus.ram_write_en = bus.c_we;
    end else begin
      bus.ram_addr     = 7'd0;
      bus.ram_din      = 16'd0;
    end
  end

  // Read-valid, shared read data and lock flag; rst masks a read already in
  // flight so it never surfaces in the cycle after reset is applied.
  always_comb begin
    bus.c_rvld = c_rvld_r && !rst;
    bus.h_rvld = h_rvld_r && !rst;
    bus.locked = in_lock_s && !rst;
    rvld_any_s = (c_rvld_r || h_rvld_r) && !rst;
    if (rvld_any_s) begin
      bus.rdata = bus.ram_dout;
    end else begin
      bus.rdata = 16'd0;
    end
  end

  // State register, read-valid pipeline and post-release marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      c_rvld_r   <= 1'b0;
      h_rvld_r   <= 1'b0;
      released_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      c_rvld_r   <= c_win_s && !bus.c_we;
      h_rvld_r   <= h_win_s && !bus.h_we;
      released_r <= lock_end_s;
    end
  end

endmodule

// File: tb/tb_simple_proc_ram_arb.sv
// tb_simple_proc_ram_arb
// Directed scenarios for the write/read path, tie alternation, burst lock
// limit, early lock exit and reset during a read, followed by randomized
// two-port traffic checked against a cycle-level reference of the arbitration
// rules and a memory-content model.
module tb_simple_proc_ram_arb;
  import simple_proc_pkg::*;

  localparam int unsigned BMAX = 8;

  logic clk = 1'b0;
  logic rst;
  logic ram_clr;
  int   checks = 0;
  int   errors = 0;

  simple_proc_ram_arb_if bus();

  simple_proc_ram_arb #(.BURST_MAX(BMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External RAM: synchronous write, registered read.
  logic [15:0] ram_mem [128];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 128; i++) ram_mem[i] <= 16'h0000;
      bus.ram_dout <= 16'h0000;
    end else begin
      if (bus.ram_write_en) ram_mem[bus.ram_addr] <= bus.ram_din;
      if (bus.ram_read_en) bus.ram_dout <= ram_mem[bus.ram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [6:0] ca, input logic [15:0] cd,
                       input logic hr, input logic hw, input logic hl, input logic [6:0] ha,
                       input logic [15:0] hd);
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.h_req = hr; bus.h_we = hw; bus.h_lock = hl; bus.h_addr = ha; bus.h_wdata = hd;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_flags"},
             {25'd0, bus.c_gnt, bus.h_gnt, bus.c_rvld, bus.h_rvld, bus.locked,
              bus.ram_read_en, bus.ram_write_en}, 32'd0);
    check_eq({tag, "_rdata"}, {16'd0, bus.rdata}, 32'd0);
    check_eq({tag, "_ramio"}, {9'd0, bus.ram_addr, bus.ram_din}, 32'd0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reference model state
  logic        m_last_host, m_lock, m_post;
  int          m_beats;
  logic [15:0] ref_mem [128];

  logic        exp_c, exp_h;
  logic        cur_c_rvld, cur_h_rvld, nxt_c_rvld, nxt_h_rvld;
  logic [15:0] cur_rdata, nxt_rdata;

  logic        c_pend, c_we_v, h_pend, h_we_v, h_lock_v, h_burst;
  logic [6:0]  c_addr_v, h_addr_v;
  logic [15:0] c_data_v, h_data_v;
  int          c_wait, h_wait, hbeat;

  initial begin
    rst = 1'b1;
    ram_clr = 1'b1;
    drive(1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;

    // Reset with both requesters active: everything quiet.
    drive(1'b1, 1'b1, 7'd5, 16'h1234, 1'b1, 1'b0, 1'b1, 7'd6, 16'h5678);
    @(negedge clk);
    check_quiet("reset");
    tick();
    rst = 1'b0;
    ram_clr = 1'b0;
    drive(1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    do_reset();

    // CPU store then load of the same word.
    drive(1'b1, 1'b1, 7'h05, 16'hBEEF, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    @(negedge clk);
    check_eq("wr_cgnt", bus.c_gnt, 1'b1);
    check_eq("wr_strobe", {bus.ram_read_en, bus.ram_write_en}, 2'b01);
    check_eq("wr_addr", bus.ram_addr, 7'h05);
    check_eq("wr_din", bus.ram_din, 16'hBEEF);
    tick();
    drive(1'b1, 1'b0, 7'h05, 16'h0000, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    @(negedge clk);
    check_eq("rd_cgnt", bus.c_gnt, 1'b1);
    check_eq("rd_strobe", {bus.ram_read_en, bus.ram_write_en}, 2'b10);
    check_eq("rd_rvld_early", bus.c_rvld, 1'b0);
    tick();
    drive(1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    @(negedge clk);
    check_eq("rd_crvld", bus.c_rvld, 1'b1);
    check_eq("rd_hrvld", bus.h_rvld, 1'b0);
    check_eq("rd_data", bus.rdata, 16'hBEEF);
    tick();

    // Both requesting from reset: C,H,C,H.
    do_reset();
    drive(1'b1, 1'b1, 7'h08, 16'h0C0C, 1'b1, 1'b1, 1'b0, 7'h09, 16'h0D0D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("tie%0d_c", i), bus.c_gnt, (i % 2) == 0);
      check_eq($sformatf("tie%0d_h", i), bus.h_gnt, (i % 2) == 1);
      tick();
    end

    // Host locked burst limited to BMAX beats, then one CPU beat, then host.
    do_reset();
    hbeat = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i >= 1, 1'b1, 7'h20, 16'hC0DE, 1'b1, 1'b1, 1'b1, 7'(7'h10 + hbeat), 16'(hbeat));
      @(negedge clk);
      check_eq($sformatf("burst%0d_h", i), bus.h_gnt, (i < 8) || (i == 9));
      check_eq($sformatf("burst%0d_c", i), bus.c_gnt, i == 8);
      check_eq($sformatf("burst%0d_lk", i), bus.locked, (i >= 1) && (i <= 7));
      if (bus.h_gnt) hbeat++;
      tick();
    end

    // Lock abandoned after 3 beats: exit, then the waiting CPU is served.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i >= 1, 1'b1, 7'h21, 16'h1111, i < 3, 1'b1, 1'b1, 7'(7'h30 + i), 16'h2222);
      @(negedge clk);
      check_eq($sformatf("early%0d_h", i), bus.h_gnt, i < 3);
      check_eq($sformatf("early%0d_c", i), bus.c_gnt, i == 4);
      check_eq($sformatf("early%0d_lk", i), bus.locked, (i >= 1) && (i <= 3));
      tick();
    end

    // Reset right after a host read grant drops the read.
    do_reset();
    drive(1'b0, 1'b0, 7'd0, 16'd0, 1'b1, 1'b0, 1'b0, 7'h05, 16'd0);
    @(negedge clk);
    check_eq("rstrd_hgnt", bus.h_gnt, 1'b1);
    check_eq("rstrd_ren", bus.ram_read_en, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    @(negedge clk);
    check_eq("rstrd_hrvld", bus.h_rvld, 1'b0);
    check_quiet("rstrd_c1");
    tick();
    @(negedge clk);
    check_quiet("rstrd_c2");
    tick();
    rst = 1'b0;

    // Randomized traffic against the reference model.
    do_reset();
    m_last_host = 1'b1; m_lock = 1'b0; m_post = 1'b0; m_beats = 0;
    cur_c_rvld = 1'b0; cur_h_rvld = 1'b0; cur_rdata = 16'd0;
    c_pend = 1'b0; h_pend = 1'b0; h_burst = 1'b0;
    c_we_v = 1'b0; h_we_v = 1'b0; h_lock_v = 1'b0;
    c_addr_v = 7'd0; h_addr_v = 7'd0; c_data_v = 16'd0; h_data_v = 16'd0;
    c_wait = 0; h_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!c_pend && ($urandom_range(0, 3) != 0)) begin
        c_pend = 1'b1;
        c_we_v = 1'($urandom_range(0, 1));
        c_addr_v = 7'h60 + 7'($urandom_range(0, 15));
        c_data_v = 16'($urandom);
      end
      if (!h_pend) begin
        if ($urandom_range(0, 15) == 0) h_burst = ~h_burst;
        if (h_burst ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0)) begin
          h_pend = 1'b1;
          h_lock_v = h_burst;
          h_we_v = 1'($urandom_range(0, 1));
          h_addr_v = 7'h60 + 7'($urandom_range(0, 15));
          h_data_v = 16'($urandom);
        end
      end
      drive(c_pend, c_we_v, c_addr_v, c_data_v, h_pend, h_we_v, h_pend && h_lock_v,
            h_addr_v, h_data_v);

      @(negedge clk);
      // Expected winner from the arbitration rules.
      exp_c = 1'b0;
      exp_h = 1'b0;
      if (m_lock) exp_h = h_pend;
      else if (c_pend && h_pend) begin
        if (m_post || m_last_host) exp_c = 1'b1;
        else exp_h = 1'b1;
      end else begin
        exp_c = c_pend;
        exp_h = h_pend;
      end

      check_eq("r_cgnt", bus.c_gnt, exp_c);
      check_eq("r_hgnt", bus.h_gnt, exp_h);
      check_eq("r_onegnt", bus.c_gnt & bus.h_gnt, 1'b0);
      check_eq("r_locked", bus.locked, m_lock);
      check_eq("r_crvld", bus.c_rvld, cur_c_rvld);
      check_eq("r_hrvld", bus.h_rvld, cur_h_rvld);
      if (cur_c_rvld || cur_h_rvld) check_eq("r_rdata", bus.rdata, cur_rdata);

      nxt_c_rvld = 1'b0;
      nxt_h_rvld = 1'b0;
      nxt_rdata = 16'd0;
      if (exp_c) begin
        check_eq("r_c_strobe", {bus.ram_read_en, bus.ram_write_en}, c_we_v ? 2'b01 : 2'b10);
        check_eq("r_c_addr", bus.ram_addr, c_addr_v);
        if (c_we_v) begin
          check_eq("r_c_din", bus.ram_din, c_data_v);
          ref_mem[c_addr_v] = c_data_v;
        end else begin
          nxt_c_rvld = 1'b1;
          nxt_rdata = ref_mem[c_addr_v];
        end
        c_pend = 1'b0;
        c_wait = 0;
      end else if (exp_h) begin
        check_eq("r_h_strobe", {bus.ram_read_en, bus.ram_write_en}, h_we_v ? 2'b01 : 2'b10);
        check_eq("r_h_addr", bus.ram_addr, h_addr_v);
        if (h_we_v) begin
          check_eq("r_h_din", bus.ram_din, h_data_v);
          ref_mem[h_addr_v] = h_data_v;
        end else begin
          nxt_h_rvld = 1'b1;
          nxt_rdata = ref_mem[h_addr_v];
        end
        h_pend = 1'b0;
        h_wait = 0;
      end else begin
        check_eq("r_idle_strobe", {bus.ram_read_en, bus.ram_write_en}, 2'b00);
      end

      // Bounded waiting for whoever was left out this cycle.
      if (c_pend) begin
        c_wait++;
        check_eq("r_c_wait", c_wait > BMAX, 1'b0);
      end
      if (h_pend) begin
        h_wait++;
        check_eq("r_h_wait", h_wait > BMAX, 1'b0);
      end

      // Advance the reference state.
      if (exp_c) m_last_host = 1'b0;
      else if (exp_h) m_last_host = 1'b1;
      if (m_lock) begin
        if (exp_h) m_beats++;
        if (!bus.h_lock || !bus.h_req || (m_beats == BMAX)) begin
          m_lock = 1'b0;
          m_post = 1'b1;
        end else begin
          m_post = 1'b0;
        end
      end else begin
        m_post = 1'b0;
        if (exp_h && bus.h_lock) begin
          m_beats = 1;
          m_lock = (BMAX > 1);
        end
      end

      tick();
      cur_c_rvld = nxt_c_rvld;
      cur_h_rvld = nxt_h_rvld;
      cur_rdata = nxt_rdata;
    end

    drive(1'b0, 1'b0, 7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 7'd0, 16'd0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
